// File: rtl/jogo_pkg.sv
// Shared types for the parametrised memory-game controller: state codes
// (exposed on db_estado) and a width helper that never returns zero.
package jogo_pkg;

    typedef enum logic [4:0] {
        INICIAL     = 5'd0,
        PREPARA     = 5'd1,
        MOSTRA      = 5'd2,
        PAUSA       = 5'd3,
        ESPERA      = 5'd4,
        COMPARA     = 5'd5,
        PROX_JOGADA = 5'd6,
        PROX_RODADA = 5'd7,
        FIM_ACERTO  = 5'd10,
        FIM_ERRO    = 5'd14,
        FIM_TIMEOUT = 5'd15
    } estado_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jogo_sequencia_param_contador.sv
// Modulo-M counter: synchronous clear (zera) has priority over count (conta);
// fim flags the terminal value M-1, after which a count wraps to zero.
module contador_m
    import jogo_pkg::*;
#(
    parameter int M = 16,
    parameter int W = clog2_min1(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] q,
    output logic         fim
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        fim   = (cnt_q == W'(M - 1));
        cnt_d = cnt_q;
        if (zera) begin
            cnt_d = '0;
        end else if (conta) begin
            cnt_d = fim ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/jogo_sequencia_param.sv
// Memory-game ("genius") controller driving an external async-read sequence ROM.
// Macro JOGO_MOSTRA_EN builds the MOSTRA/PAUSA LED replay phase; otherwise leds echo chaves.
module jogo_sequencia_param
    import jogo_pkg::*;
#(
    parameter int N_CHAVES       = 4,
    parameter int MAX_RODADAS    = 16,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int MOSTRA_CICLOS  = 500,
    parameter int AW             = clog2_min1(MAX_RODADAS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [N_CHAVES-1:0] chaves,
    output logic [AW-1:0]       mem_addr,
    input  logic [N_CHAVES-1:0] mem_data,
    output logic [N_CHAVES-1:0] leds,
    output logic                pronto,
    output logic                acertou,
    output logic                errou,
    output logic                timeout,
    output logic                aguarda_jogada,
    output logic [AW-1:0]       db_rodada,
    output logic [AW-1:0]       db_jogada,
    output logic [4:0]          db_estado
);

    localparam int TW = clog2_min1(TIMEOUT_CICLOS);

    estado_t             estado_q, estado_d;
    logic                zero_ant_q, zero_ant_d;
    logic [N_CHAVES-1:0] jogada_val_q, jogada_val_d;
    logic                jogada_det;

    logic          rod_zera, rod_conta, rod_fim;
    logic [AW-1:0] rod_q;
    logic          jog_zera, jog_conta, jog_fim_unused;
    logic [AW-1:0] jog_q;
    logic          to_zera, to_conta, to_fim;
    logic [TW-1:0] to_cnt_unused;

    // A play is the rising edge of "any switch on"; holding or adding switches is ignored.
    assign jogada_det = (|chaves) && zero_ant_q;

    contador_m #(.M(MAX_RODADAS), .W(AW)) u_rodada (
        .clock(clock), .reset(reset), .zera(rod_zera), .conta(rod_conta),
        .q(rod_q), .fim(rod_fim)
    );

    contador_m #(.M(MAX_RODADAS), .W(AW)) u_jogada (
        .clock(clock), .reset(reset), .zera(jog_zera), .conta(jog_conta),
        .q(jog_q), .fim(jog_fim_unused)
    );

    // Timeout counter saturates at its terminal count instead of wrapping.
    assign to_zera  = (estado_q != ESPERA) || jogada_det;
    assign to_conta = ~to_fim;

    contador_m #(.M(TIMEOUT_CICLOS), .W(TW)) u_timeout (
        .clock(clock), .reset(reset), .zera(to_zera), .conta(to_conta),
        .q(to_cnt_unused), .fim(to_fim)
    );

`ifdef JOGO_MOSTRA_EN
    localparam int DW = clog2_min1(MOSTRA_CICLOS);

    logic          idx_zera, idx_conta, idx_fim_unused;
    logic [AW-1:0] idx_q;
    logic          disp_zera, disp_fim;
    logic [DW-1:0] disp_cnt_unused;

    contador_m #(.M(MAX_RODADAS), .W(AW)) u_indice (
        .clock(clock), .reset(reset), .zera(idx_zera), .conta(idx_conta),
        .q(idx_q), .fim(idx_fim_unused)
    );

    // Restarting on its own terminal count gives each MOSTRA and PAUSA exactly MOSTRA_CICLOS cycles.
    assign disp_zera = !((estado_q == MOSTRA) || (estado_q == PAUSA)) || disp_fim;

    contador_m #(.M(MOSTRA_CICLOS), .W(DW)) u_exibe (
        .clock(clock), .reset(reset), .zera(disp_zera), .conta(1'b1),
        .q(disp_cnt_unused), .fim(disp_fim)
    );
`endif

    always_comb begin
        zero_ant_d   = ~|chaves;
        jogada_val_d = jogada_val_q;
        if ((estado_q == ESPERA) && jogada_det) begin
            jogada_val_d = chaves;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        rod_zera  = 1'b0;
        rod_conta = 1'b0;
        jog_zera  = 1'b0;
        jog_conta = 1'b0;
`ifdef JOGO_MOSTRA_EN
        idx_zera  = 1'b0;
        idx_conta = 1'b0;
`endif
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARA;
            end
            PREPARA: begin
                rod_zera = 1'b1;
                jog_zera = 1'b1;
`ifdef JOGO_MOSTRA_EN
                idx_zera = 1'b1;
                estado_d = MOSTRA;
`else
                estado_d = ESPERA;
`endif
            end
`ifdef JOGO_MOSTRA_EN
            MOSTRA: begin
                if (disp_fim) estado_d = PAUSA;
            end
            PAUSA: begin
                if (disp_fim) begin
                    if (idx_q < rod_q) begin
                        idx_conta = 1'b1;
                        estado_d  = MOSTRA;
                    end else begin
                        jog_zera = 1'b1;
                        estado_d = ESPERA;
                    end
                end
            end
`endif
            ESPERA: begin
                if (jogada_det) begin
                    estado_d = COMPARA;
                end else if (to_fim) begin
                    estado_d = FIM_TIMEOUT;
                end
            end
            COMPARA: begin
                if (jogada_val_q != mem_data) begin
                    estado_d = FIM_ERRO;
                end else if (jog_q < rod_q) begin
                    estado_d = PROX_JOGADA;
                end else if (rod_fim) begin
                    estado_d = FIM_ACERTO;
                end else begin
                    estado_d = PROX_RODADA;
                end
            end
            PROX_JOGADA: begin
                jog_conta = 1'b1;
                estado_d  = ESPERA;
            end
            PROX_RODADA: begin
                rod_conta = 1'b1;
                jog_zera  = 1'b1;
`ifdef JOGO_MOSTRA_EN
                idx_zera  = 1'b1;
                estado_d  = MOSTRA;
`else
                estado_d  = ESPERA;
`endif
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) estado_d = PREPARA;
            end
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= INICIAL;
            zero_ant_q   <= 1'b0;
            jogada_val_q <= '0;
        end else begin
            estado_q     <= estado_d;
            zero_ant_q   <= zero_ant_d;
            jogada_val_q <= jogada_val_d;
        end
    end

    always_comb begin
        pronto         = (estado_q == FIM_ACERTO) || (estado_q == FIM_ERRO) ||
                         (estado_q == FIM_TIMEOUT);
        acertou        = (estado_q == FIM_ACERTO);
        errou          = (estado_q == FIM_ERRO);
        timeout        = (estado_q == FIM_TIMEOUT);
        aguarda_jogada = (estado_q == ESPERA);
        db_rodada      = rod_q;
        db_jogada      = jog_q;
        db_estado      = estado_q;
        mem_addr       = jog_q;
`ifdef JOGO_MOSTRA_EN
        leds = '0;
        if ((estado_q == MOSTRA) || (estado_q == PAUSA)) mem_addr = idx_q;
        if (estado_q == MOSTRA) leds = mem_data;
        if (estado_q == ESPERA) leds = chaves;
`else
        leds = chaves;
`endif
    end

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Self-checking bench for jogo_sequencia_param with a small ROM; honours JOGO_MOSTRA_EN.
module tb_jogo_sequencia_param;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int TO = 20;
    localparam int MC = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         iniciar = 1'b0;
    logic [N-1:0] chaves = '0;
    logic [1:0]   mem_addr;
    logic [N-1:0] mem_data;
    logic [N-1:0] leds;
    logic         pronto, acertou, errou, timeout, aguarda_jogada;
    logic [1:0]   db_rodada, db_jogada;
    logic [4:0]   db_estado;

    logic [N-1:0] rom [0:R-1];
    logic [N-1:0] seq [0:R-1];
    int total = 0;
    int bad = 0;

    assign mem_data = rom[mem_addr];

    jogo_sequencia_param #(
        .N_CHAVES(N), .MAX_RODADAS(R), .TIMEOUT_CICLOS(TO), .MOSTRA_CICLOS(MC)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .mem_addr(mem_addr), .mem_data(mem_data), .leds(leds), .pronto(pronto),
        .acertou(acertou), .errou(errou), .timeout(timeout),
        .aguarda_jogada(aguarda_jogada), .db_rodada(db_rodada),
        .db_jogada(db_jogada), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [N-1:0] v, input int hold, input int rel);
        chaves = v;
        cyc(hold);
        chaves = '0;
        cyc(rel);
    endtask

    task automatic wait_espera(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (aguarda_jogada) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic do_reset();
        chaves = '0;
        iniciar = 1'b0;
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        cyc(1);
        iniciar = 1'b0;
    endtask

    task automatic load_fixed();
        for (int i = 0; i < R; i++) begin
            seq[i] = 4'b0001 << i;
            rom[i] = seq[i];
        end
    endtask

    task automatic test_reset();
        cyc(2);
        total++; if (db_estado !== 5'd0) begin bad++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
        total++; if ({pronto, acertou, errou, timeout, aguarda_jogada} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {pronto, acertou, errou, timeout, aguarda_jogada}); end
        total++; if ({db_rodada, db_jogada, mem_addr, leds} !== 10'b0) begin bad++; $display("FAIL reset_cnt: got %b want 0", {db_rodada, db_jogada, mem_addr, leds}); end
        reset = 1'b0;
        cyc(3);
        total++; if (db_estado !== 5'd0) begin bad++; $display("FAIL idle_inicial: got %0d want 0", db_estado); end
    endtask

    task automatic test_win();
        bit ok;
        do_reset();
        load_fixed();
        start_game();
        for (int r = 0; r < R; r++) begin
            wait_espera(ok);
            total++; if (!ok) begin bad++; $display("FAIL win_wait: got no ESPERA want ESPERA round %0d", r); end
            total++; if (db_rodada !== 2'(r)) begin bad++; $display("FAIL win_rodada: got %0d want %0d", db_rodada, r); end
            for (int j = 0; j <= r; j++) press(seq[j], 5, 5);
        end
        total++; if ({pronto, acertou, errou, timeout} !== 4'b1100) begin bad++; $display("FAIL win_flags: got %b want 1100", {pronto, acertou, errou, timeout}); end
        total++; if (db_estado !== 5'd10) begin bad++; $display("FAIL win_estado: got %0d want 10", db_estado); end
    endtask

    task automatic test_error();
        bit ok;
        do_reset();
        load_fixed();
        start_game();
        for (int r = 0; r < 2; r++) begin
            wait_espera(ok);
            for (int j = 0; j <= r; j++) press(seq[j], 5, 5);
        end
        wait_espera(ok);
        press(seq[0], 5, 5);
        wait_espera(ok);
        total++; if (!ok || db_jogada !== 2'd1) begin bad++; $display("FAIL err_setup: got jogada %0d want 1", db_jogada); end
        chaves = 4'b0100;
        cyc(1);
        total++; if (db_estado !== 5'd5) begin bad++; $display("FAIL err_compara: got %0d want 5", db_estado); end
        cyc(1);
        total++; if ({pronto, acertou, errou, timeout} !== 4'b1010) begin bad++; $display("FAIL err_flags: got %b want 1010", {pronto, acertou, errou, timeout}); end
        total++; if (db_rodada !== 2'd2 || db_jogada !== 2'd1) begin bad++; $display("FAIL err_idx: got %0d/%0d want 2/1", db_rodada, db_jogada); end
        chaves = '0;
        cyc(2);
    endtask

    task automatic test_restart();
        bit ok;
        iniciar = 1'b1;
        cyc(1);
        iniciar = 1'b0;
        total++; if ({pronto, errou} !== 2'b00 || db_estado !== 5'd1) begin bad++; $display("FAIL rst_prep: got %b estado %0d want 00 estado 1", {pronto, errou}, db_estado); end
        cyc(1);
        total++; if (db_rodada !== 2'd0) begin bad++; $display("FAIL rst_rodada: got %0d want 0", db_rodada); end
`ifdef JOGO_MOSTRA_EN
        for (int i = 0; i < MC; i++) begin
            total++; if (leds !== seq[0] || db_estado !== 5'd2) begin bad++; $display("FAIL rst_mostra: got leds %b estado %0d want %b 2", leds, db_estado, seq[0]); end
            cyc(1);
        end
        total++; if (leds !== 4'b0) begin bad++; $display("FAIL rst_pausa: got %b want 0000", leds); end
`else
        total++; if (aguarda_jogada !== 1'b1) begin bad++; $display("FAIL rst_aguarda: got %b want 1", aguarda_jogada); end
`endif
        wait_espera(ok);
        iniciar = 1'b1;
        cyc(3);
        iniciar = 1'b0;
        total++; if (db_estado !== 5'd4) begin bad++; $display("FAIL iniciar_ignorado: got %0d want 4", db_estado); end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        load_fixed();
        start_game();
        wait_espera(ok);
        total++; if (!ok) begin bad++; $display("FAIL to_wait: got no ESPERA want ESPERA"); end
        for (int k = 1; k <= TO; k++) begin
            cyc(1);
            total++; if (timeout !== (k == TO)) begin bad++; $display("FAIL to_cycle%0d: got %b want %b", k, timeout, (k == TO)); end
        end
        total++; if (pronto !== 1'b1 || db_estado !== 5'd15) begin bad++; $display("FAIL to_estado: got %b/%0d want 1/15", pronto, db_estado); end
        start_game();
        wait_espera(ok);
        cyc(TO - 1);
        chaves = seq[0];
        cyc(1);
        total++; if (timeout !== 1'b0 || db_estado !== 5'd5) begin bad++; $display("FAIL to_late_play: got %b/%0d want 0/5", timeout, db_estado); end
        chaves = '0;
        cyc(5);
        total++; if (pronto !== 1'b0 || db_rodada !== 2'd1) begin bad++; $display("FAIL to_late_next: got %b/%0d want 0/1", pronto, db_rodada); end
    endtask

    task automatic test_held();
        bit ok;
        do_reset();
        load_fixed();
        start_game();
        wait_espera(ok);
        chaves = seq[0];
        cyc(50);
        total++; if (timeout !== 1'b1 || db_rodada !== 2'd1 || db_jogada !== 2'd0) begin bad++; $display("FAIL held: got to %b rod %0d jog %0d want 1 1 0", timeout, db_rodada, db_jogada); end
        chaves = '0;
        cyc(1);
        start_game();
        wait_espera(ok);
        press(4'b0011, 3, 3);
        total++; if (errou !== 1'b1 || db_jogada !== 2'd0) begin bad++; $display("FAIL multihot: got %b/%0d want 1/0", errou, db_jogada); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        load_fixed();
        start_game();
        wait_espera(ok);
        press(seq[0], 1, 3);
`ifdef JOGO_MOSTRA_EN
        total++; if (db_estado !== 5'd2) begin bad++; $display("FAIL mid_mostra: got %0d want 2", db_estado); end
`endif
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        total++; if (db_estado !== 5'd0 || leds !== 4'b0) begin bad++; $display("FAIL mid_estado: got %0d leds %b want 0 0000", db_estado, leds); end
        total++; if ({pronto, acertou, errou, timeout, aguarda_jogada} !== 5'b0 || db_rodada !== 2'd0) begin bad++; $display("FAIL mid_flags: got %b rod %0d want 00000 0", {pronto, acertou, errou, timeout, aguarda_jogada}, db_rodada); end
        start_game();
        wait_espera(ok);
        total++; if (!ok || db_rodada !== 2'd0 || mem_addr !== 2'd0) begin bad++; $display("FAIL mid_replay: got rod %0d addr %0d want 0 0", db_rodada, mem_addr); end
    endtask

    task automatic test_random_games();
        bit ok;
        bit done;
        bit wrong;
        logic [N-1:0] v;
        for (int g = 0; g < 8; g++) begin
            do_reset();
            for (int i = 0; i < R; i++) begin
                seq[i] = 4'b0001 << $urandom_range(0, N - 1);
                rom[i] = seq[i];
            end
            start_game();
            done = 1'b0;
            for (int r = 0; r < R && !done; r++) begin
                wait_espera(ok);
                total++; if (!ok || db_rodada !== 2'(r)) begin bad++; $display("FAIL rnd_round: got ok %b rod %0d want 1 %0d", ok, db_rodada, r); end
                for (int j = 0; j <= r && !done; j++) begin
                    wrong = ($urandom_range(0, 11) == 0);
                    v = seq[j];
                    if (wrong) begin
                        do v = 4'($urandom_range(1, 15)); while (v == seq[j]);
                    end
                    press(v, $urandom_range(1, 6), $urandom_range(3, 6));
                    if (wrong) begin
                        done = 1'b1;
                        total++; if ({pronto, errou} !== 2'b11 || db_rodada !== 2'(r) || db_jogada !== 2'(j)) begin bad++; $display("FAIL rnd_err: got %b %0d/%0d want 11 %0d/%0d", {pronto, errou}, db_rodada, db_jogada, r, j); end
                    end else if (j == r && r == R - 1) begin
                        done = 1'b1;
                        total++; if ({pronto, acertou} !== 2'b11) begin bad++; $display("FAIL rnd_win: got %b want 11", {pronto, acertou}); end
                    end else if (j < r) begin
                        total++; if (aguarda_jogada !== 1'b1 || db_jogada !== 2'(j + 1)) begin bad++; $display("FAIL rnd_next: got %b/%0d want 1/%0d", aguarda_jogada, db_jogada, j + 1); end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_win();
        test_error();
        test_restart();
        test_timeout();
        test_held();
        test_reset_mid();
        test_random_games();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
